// File: rtl/game_pkg.sv
// game_pkg: shared types for the battle-flow controller.
//   state_t      - top-level game state, codes consumed by the pixel mux
//   anim_phase_t - game-over animation phase
//   STATE_W      - width of state_t
package game_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        MENU   = 4'b0000,
        PLAYER = 4'b0001,
        ENEMY  = 4'b1000,
        OVER   = 4'b1111
    } state_t;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        DIVIDED = 2'd1,
        FALL    = 2'd2
    } anim_phase_t;

endpackage

// File: rtl/turn_sequencer_phase_timer.sv
// phase_timer: load/enable down-counter with a terminal-count flag.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (count -> 0)
//   i_load      - load i_load_val (takes precedence over counting)
//   i_load_val  - value loaded; the phase then lasts i_load_val+1 enabled cycles
//   i_en        - count down while enabled; holds at zero
//   o_tc        - high while enabled with the count at zero
module phase_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // Independent of i_load so the owner may reload in the terminal cycle.
    assign o_tc = i_en && (r_count == '0);

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: battle-flow controller. Sequences MENU -> PLAYER -> ENEMY
// -> MENU on rising edges of the phase done inputs, pre-empts to OVER on
// game_over, counts completed enemy turns and runs the game-over animation.
// Optional macro TURN_TIMEOUT_EN: PLAYER ends on its own after
// PLAYER_TIMEOUT_CYCLES cycles without a player_done rise.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   menu_done_in          - menu finished (rising edge is the event)
//   player_done_in        - player finished (rising edge is the event)
//   enemy_done_in         - enemy finished (rising edge is the event)
//   game_over_in          - player HP zero (rising edge is the event)
//   state_out             - game_pkg::state_t code
//   round_rst_out         - one-cycle pulse on ENEMY -> MENU
//   round_count_out       - completed enemy turns, saturating
//   anim_phase_out        - 0 hold, 1 divided, 2 fall-apart; 0 outside OVER
//   divided_out           - split-heart enable
//   fall_apart_valid_out  - fall-apart start/enable
module turn_sequencer
    import game_pkg::*;
#(
    parameter int unsigned HEART_HOLD_CYCLES     = 65000000,
    parameter int unsigned DIVIDE_HOLD_CYCLES    = 130000000,
    parameter int unsigned PLAYER_TIMEOUT_CYCLES = 650000000,
    parameter int unsigned ROUND_W               = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               menu_done_in,
    input  logic               player_done_in,
    input  logic               enemy_done_in,
    input  logic               game_over_in,
    output logic [STATE_W-1:0] state_out,
    output logic               round_rst_out,
    output logic [ROUND_W-1:0] round_count_out,
    output logic [1:0]         anim_phase_out,
    output logic               divided_out,
    output logic               fall_apart_valid_out
);

    if (HEART_HOLD_CYCLES == 0 || DIVIDE_HOLD_CYCLES == 0 || PLAYER_TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("turn_sequencer: cycle-count parameters must be non-zero");
    end

    localparam logic [31:0] HOLD_LOAD   = 32'(HEART_HOLD_CYCLES - 1);
    localparam logic [31:0] DIVIDE_LOAD = 32'(DIVIDE_HOLD_CYCLES - 1);

    state_t             r_state, w_next_state;
    logic               r_round_rst, w_next_round_rst;
    logic [ROUND_W-1:0] r_round_count, w_next_round_count;
    anim_phase_t        r_anim_phase, w_next_anim_phase;
    logic               r_divided, w_next_divided;
    logic               r_fall_valid, w_next_fall_valid;

    logic r_menu_prev, r_player_prev, r_enemy_prev, r_go_prev;
    logic w_menu_ev, w_player_ev, w_enemy_ev, w_go_ev;

    logic        w_anim_load, w_anim_en, w_anim_tc;
    logic [31:0] w_anim_load_val;
    logic        w_to_tc;

    assign w_menu_ev   = menu_done_in   && !r_menu_prev;
    assign w_player_ev = player_done_in && !r_player_prev;
    assign w_enemy_ev  = enemy_done_in  && !r_enemy_prev;
    assign w_go_ev     = game_over_in   && !r_go_prev;

    phase_timer #(.WIDTH(32)) u_anim_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_anim_load),
        .i_load_val (w_anim_load_val),
        .i_en       (w_anim_en),
        .o_tc       (w_anim_tc)
    );

`ifdef TURN_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LOAD = 32'(PLAYER_TIMEOUT_CYCLES - 1);

    // Reloaded in every other state, so it is fresh on the first PLAYER cycle.
    phase_timer #(.WIDTH(32)) u_turn_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state != PLAYER),
        .i_load_val (TIMEOUT_LOAD),
        .i_en       (r_state == PLAYER),
        .o_tc       (w_to_tc)
    );
`else
    assign w_to_tc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= MENU;
            r_round_rst   <= 1'b0;
            r_round_count <= '0;
            r_anim_phase  <= HOLD;
            r_divided     <= 1'b0;
            r_fall_valid  <= 1'b0;
            r_menu_prev   <= 1'b0;
            r_player_prev <= 1'b0;
            r_enemy_prev  <= 1'b0;
            r_go_prev     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_round_rst   <= w_next_round_rst;
            r_round_count <= w_next_round_count;
            r_anim_phase  <= w_next_anim_phase;
            r_divided     <= w_next_divided;
            r_fall_valid  <= w_next_fall_valid;
            r_menu_prev   <= menu_done_in;
            r_player_prev <= player_done_in;
            r_enemy_prev  <= enemy_done_in;
            r_go_prev     <= game_over_in;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        w_next_round_rst   = 1'b0;
        w_next_round_count = r_round_count;
        w_next_anim_phase  = r_anim_phase;
        w_next_divided     = r_divided;
        w_next_fall_valid  = r_fall_valid;
        w_anim_load        = 1'b0;
        w_anim_load_val    = HOLD_LOAD;
        w_anim_en          = 1'b0;

        if (r_state != OVER && w_go_ev) begin
            w_next_state      = OVER;
            w_next_anim_phase = HOLD;
            w_next_divided    = 1'b0;
            w_next_fall_valid = 1'b0;
            w_anim_load       = 1'b1;
        end else begin
            case (r_state)
                MENU: begin
                    if (w_menu_ev) w_next_state = PLAYER;
                end
                PLAYER: begin
                    if (w_player_ev || w_to_tc) w_next_state = ENEMY;
                end
                ENEMY: begin
                    if (w_enemy_ev) begin
                        w_next_state     = MENU;
                        w_next_round_rst = 1'b1;
                        if (r_round_count != '1) begin
                            w_next_round_count = r_round_count + ROUND_W'(1);
                        end
                    end
                end
                OVER: begin
                    // Counter freezes once the fall-apart phase is reached.
                    w_anim_en = (r_anim_phase != FALL);
                    if (w_anim_tc) begin
                        if (r_anim_phase == HOLD) begin
                            w_next_anim_phase = DIVIDED;
                            w_next_divided    = 1'b1;
                            w_anim_load       = 1'b1;
                            w_anim_load_val   = DIVIDE_LOAD;
                        end else if (r_anim_phase == DIVIDED) begin
                            w_next_anim_phase = FALL;
                            w_next_fall_valid = 1'b1;
                        end
                    end
                end
                default: w_next_state = MENU;
            endcase
        end
    end

    assign state_out            = r_state;
    assign round_rst_out        = r_round_rst;
    assign round_count_out      = r_round_count;
    assign anim_phase_out       = r_anim_phase;
    assign divided_out          = r_divided;
    assign fall_apart_valid_out = r_fall_valid;

endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       menu_done_in, player_done_in, enemy_done_in, game_over_in;
    logic [3:0] state_out;
    logic       round_rst_out;
    logic [7:0] round_count_out;
    logic [1:0] anim_phase_out;
    logic       divided_out, fall_apart_valid_out;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] S_MENU   = 4'b0000;
    localparam logic [3:0] S_PLAYER = 4'b0001;
    localparam logic [3:0] S_ENEMY  = 4'b1000;
    localparam logic [3:0] S_OVER   = 4'b1111;

    typedef struct {
        string       tag;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    turn_sequencer #(
        .HEART_HOLD_CYCLES     (4),
        .DIVIDE_HOLD_CYCLES    (6),
        .PLAYER_TIMEOUT_CYCLES (10),
        .ROUND_W               (8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .menu_done_in         (menu_done_in),
        .player_done_in       (player_done_in),
        .enemy_done_in        (enemy_done_in),
        .game_over_in         (game_over_in),
        .state_out            (state_out),
        .round_rst_out        (round_rst_out),
        .round_count_out      (round_count_out),
        .anim_phase_out       (anim_phase_out),
        .divided_out          (divided_out),
        .fall_apart_valid_out (fall_apart_valid_out)
    );

    function automatic logic [16:0] pk(logic [3:0] s, logic r, logic [7:0] c,
                                       logic [1:0] p, logic d, logic f);
        return {s, r, c, p, d, f};
    endfunction

    // Push the expectation for the cycle following the current inputs,
    // clock once, then pop it and compare against the DUT.
    task automatic tick(input string tag, input logic [3:0] s, input logic r,
                        input logic [7:0] c, input logic [1:0] p,
                        input logic d, input logic f);
        exp_t e, got;
        logic [16:0] obs;
        e.tag = tag;
        e.v   = pk(s, r, c, p, d, f);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        obs = pk(state_out, round_rst_out, round_count_out, anim_phase_out,
                 divided_out, fall_apart_valid_out);
        checks++;
        assert (obs === got.v) else begin
            errors++;
            $error("FAIL %s: observed state=%b rrst=%b cnt=%0d ph=%0d div=%b fall=%b expected state=%b rrst=%b cnt=%0d ph=%0d div=%b fall=%b",
                   got.tag, obs[16:13], obs[12], obs[11:4], obs[3:2], obs[1], obs[0],
                   got.v[16:13], got.v[12], got.v[11:4], got.v[3:2], got.v[1], got.v[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        menu_done_in = 1'b0; player_done_in = 1'b0;
        enemy_done_in = 1'b0; game_over_in = 1'b0;
        tick("reset", S_MENU, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick("idle", S_MENU, 0, 0, 0, 0, 0);

        // Held menu level: exactly one transition.
        menu_done_in = 1'b1;
        tick("menu_rise", S_PLAYER, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick("menu_held", S_PLAYER, 0, 0, 0, 0, 0);
        menu_done_in = 1'b0;
        player_done_in = 1'b1;
        tick("player_rise", S_ENEMY, 0, 0, 0, 0, 0);
        player_done_in = 1'b0;
        enemy_done_in = 1'b1;
        tick("enemy_rise", S_MENU, 1, 1, 0, 0, 0);
        enemy_done_in = 1'b0;
        tick("rrst_one_cycle", S_MENU, 0, 1, 0, 0, 0);

        // Mismatched events in MENU are dropped.
        enemy_done_in = 1'b1;
        tick("menu_ign_enemy", S_MENU, 0, 1, 0, 0, 0);
        enemy_done_in = 1'b0;
        player_done_in = 1'b1;
        tick("menu_ign_player", S_MENU, 0, 1, 0, 0, 0);

        // player_done held from MENU: no edge inside PLAYER until it re-rises.
        menu_done_in = 1'b1;
        tick("menu_rise2", S_PLAYER, 0, 1, 0, 0, 0);
        menu_done_in = 1'b0;
        for (int i = 0; i < 4; i++) tick("player_held", S_PLAYER, 0, 1, 0, 0, 0);
        player_done_in = 1'b0;
        tick("player_fall", S_PLAYER, 0, 1, 0, 0, 0);
        player_done_in = 1'b1;
        tick("player_rerise", S_ENEMY, 0, 1, 0, 0, 0);
        player_done_in = 1'b0;
        enemy_done_in = 1'b1;
        tick("enemy_rise2", S_MENU, 1, 2, 0, 0, 0);
        enemy_done_in = 1'b0;

        // Game-over pre-empts a same-cycle enemy_done.
        menu_done_in = 1'b1;
        tick("menu_rise3", S_PLAYER, 0, 2, 0, 0, 0);
        menu_done_in = 1'b0;
        player_done_in = 1'b1;
        tick("player_rise3", S_ENEMY, 0, 2, 0, 0, 0);
        player_done_in = 1'b0;
        tick("enemy_wait", S_ENEMY, 0, 2, 0, 0, 0);
        game_over_in = 1'b1;
        enemy_done_in = 1'b1;
        tick("over_T1", S_OVER, 0, 2, 0, 0, 0);
        enemy_done_in = 1'b0;
        menu_done_in = 1'b1;
        tick("over_T2", S_OVER, 0, 2, 0, 0, 0);
        menu_done_in = 1'b0;
        player_done_in = 1'b1;
        tick("over_T3", S_OVER, 0, 2, 0, 0, 0);
        player_done_in = 1'b0;
        enemy_done_in = 1'b1;
        tick("over_T4", S_OVER, 0, 2, 0, 0, 0);
        enemy_done_in = 1'b0;
        for (int i = 5; i <= 10; i++) tick("over_divided", S_OVER, 0, 2, 1, 1, 0);
        for (int i = 11; i <= 16; i++) tick("over_fall", S_OVER, 0, 2, 2, 1, 1);

        // game_over held through reset release counts as a fresh edge.
        rst = 1'b1;
        tick("rst_from_fall", S_MENU, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick("over2_T1", S_OVER, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 4; i++) tick("over2_hold", S_OVER, 0, 0, 0, 0, 0);
        for (int i = 5; i <= 7; i++) tick("over2_divided", S_OVER, 0, 0, 1, 1, 0);
        rst = 1'b1;
        game_over_in = 1'b0;
        tick("rst_mid_anim", S_MENU, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick("after_rst", S_MENU, 0, 0, 0, 0, 0);

        // Player turn without player_done.
        menu_done_in = 1'b1;
        tick("timeout_entry", S_PLAYER, 0, 0, 0, 0, 0);
        menu_done_in = 1'b0;
`ifdef TURN_TIMEOUT_EN
        for (int i = 1; i < 10; i++) tick("timeout_wait", S_PLAYER, 0, 0, 0, 0, 0);
        tick("timeout_fire", S_ENEMY, 0, 0, 0, 0, 0);
`else
        for (int i = 1; i <= 1000; i++) tick("no_timeout", S_PLAYER, 0, 0, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
